// File: rtl/bt_uart_rx_fifo.sv
// bt_uart_rx_fifo: 8N1 UART receiver (16x oversampling) feeding a first-word-fall-through byte FIFO.
// Ports: clk_clk/reset_reset_n (async active-low reset); uart_rxd serial input (idles high);
//        rx_data/rx_valid/rx_ready FIFO head handshake; frame_err 1-clk pulse on a low stop bit;
//        overrun sticky drop flag cleared by overrun_clr; fifo_count occupied entries.
module bt_uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVS_DIV    = CLK_HZ / (BAUD * 16),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(OVS_DIV + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    smp_q, smp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          tick, mid, push_req, push, pop, full;
    assign fifo_count = wr_q - rd_q;
    assign rx_valid   = fifo_count != '0;
    assign full       = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign rx_data    = rx_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    always_comb begin
        tick        = div_q == DW'(OVS_DIV - 1);
        mid         = tick && smp_q == 4'd7;
        div_d       = tick ? '0 : div_q + 1'b1;
        smp_d       = tick ? smp_q + 4'd1 : smp_q;
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: if (!rxs_q) begin
                // Realign the tick grid to the start edge so mid-bit lands mid-bit.
                state_d = START;
                div_d   = '0;
                smp_d   = '0;
                bit_d   = '0;
            end
            START: if (mid) state_d = rxs_q ? IDLE : DATA;
            DATA: if (mid) begin
                shift_d = {rxs_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (mid) begin
                push_req    = rxs_q;
                frame_err_d = !rxs_q;
                state_d     = rxs_q ? IDLE : BRK;
            end
            BRK: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pop  = rx_valid && rx_ready;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push = push_req && (!full || pop);
        wr_d = wr_q + (AW+1)'(push);
        rd_d = rd_q + (AW+1)'(pop);
        overrun_d = (push_req && !push) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            div_q       <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            rx_meta_q   <= uart_rxd;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            div_q       <= div_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= shift_q;
    end
endmodule

// File: tb/tb_bt_uart_rx_fifo.sv
// tb_bt_uart_rx_fifo: directed and randomized checks of bt_uart_rx_fifo against a byte-queue model.
module tb_bt_uart_rx_fifo;
    logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b0, overrun_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [3:0] fifo_count;
    int         tests = 0, fails = 0, fe_cnt = 0, vcyc = 0;
    logic       exp_ovr, done;
    logic [7:0] got[$], exp_q[$];
    always #5 clk = ~clk;
    bt_uart_rx_fifo #(.CLK_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(8)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .uart_rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .overrun_clr(overrun_clr),
        .fifo_count(fifo_count)
    );
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (rx_valid) vcyc++;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask
    task automatic chk_q(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk({tag, "_byte"}, got[i], exp_q[i]);
    endtask
    task automatic bitw(input logic v);
        rxd = v;
        tick(16);
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        bitw(1'b0);
        for (int i = 0; i < 8; i++) bitw(b[i]);
        bitw(stop);
        if (stop) rxd = 1'b1;
    endtask
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < 8) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask
    initial begin
        tick(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick(5);
        // single byte with exact valid timing
        rx_ready = 1'b1;
        got.delete();
        fork
            send(8'hA5, 1'b1);
            begin
                tick(154);
                chk("t1_pre", rx_valid, 0);
                tick(1);
                chk("t1_valid", rx_valid, 1);
                chk("t1_data", rx_data, 8'hA5);
                tick(1);
                chk("t1_drop", rx_valid, 0);
            end
        join
        tick(4);
        exp_q = {8'hA5};
        chk_q("t1");
        chk("t1_fe", fe_cnt, 0);
        chk("t1_overrun", overrun, 0);
        // glitch on the start bit
        got.delete();
        vcyc = 0;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        chk("t2_novalid", vcyc, 0);
        chk("t2_fe", fe_cnt, 0);
        send(8'h3C, 1'b1);
        tick(4);
        exp_q = {8'h3C};
        chk_q("t2");
        // framing error with held-low line
        got.delete();
        fe_cnt = 0;
        send(8'h55, 1'b0);
        rxd = 1'b0;
        tick(40);
        chk("t3_fe", fe_cnt, 1);
        chk("t3_count", fifo_count, 0);
        rxd = 1'b1;
        tick(20);
        chk("t3_fe_after", fe_cnt, 1);
        send(8'h81, 1'b1);
        tick(4);
        exp_q = {8'h81};
        chk_q("t3");
        // overrun
        rx_ready = 1'b0;
        got.delete();
        exp_q.delete();
        exp_ovr = 1'b0;
        for (int b = 0; b < 9; b++) begin
            send(8'(b), 1'b1);
            model_push(8'(b));
        end
        tick(4);
        chk("t4_count", fifo_count, exp_q.size());
        chk("t4_overrun", overrun, exp_ovr);
        rx_ready = 1'b1;
        tick(12);
        rx_ready = 1'b0;
        chk_q("t4");
        chk("t4_empty", fifo_count, 0);
        chk("t4_sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("t4_clr", overrun, 0);
        // full FIFO with pop in the push cycle
        got.delete();
        exp_q.delete();
        exp_ovr = 1'b0;
        for (int b = 0; b < 8; b++) begin
            send(8'h40 + 8'(b), 1'b1);
            model_push(8'h40 + 8'(b));
        end
        tick(4);
        chk("t5_full", fifo_count, 8);
        fork
            send(8'hEE, 1'b1);
            begin
                tick(154);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'hEE);
        tick(4);
        chk("t5_count", fifo_count, 8);
        chk("t5_overrun", overrun, exp_ovr);
        rx_ready = 1'b1;
        tick(12);
        rx_ready = 1'b0;
        chk_q("t5");
        // reset mid-frame
        got.delete();
        send(8'h77, 1'b1);
        tick(4);
        chk("t6_pre_count", fifo_count, 1);
        fork
            send(8'hF0, 1'b1);
            begin
                tick(88);
                rst_n = 1'b0;
                #1;
                chk("t6_valid", rx_valid, 0);
                chk("t6_data", rx_data, 0);
                chk("t6_count", fifo_count, 0);
                chk("t6_overrun", overrun, 0);
                chk("t6_fe", frame_err, 0);
                tick(3);
                rst_n = 1'b1;
            end
        join
        tick(10);
        send(8'h12, 1'b1);
        tick(4);
        chk("t6_post_count", fifo_count, 1);
        chk("t6_post_data", rx_data, 8'h12);
        rx_ready = 1'b1;
        tick(4);
        // randomized bytes, gaps and consumer backpressure
        got.delete();
        exp_q.delete();
        exp_ovr = 1'b0;
        fe_cnt = 0;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    send(b, 1'b1);
                    exp_q.push_back(b);
                    tick($urandom_range(0, 20));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rx_ready = 1'b1;
        tick(12);
        chk_q("rnd");
        chk("rnd_overrun", overrun, exp_ovr);
        chk("rnd_fe", fe_cnt, 0);
        chk("rnd_empty", fifo_count, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
